// File: rtl/sram_arbiter_ctrl.sv
// Round-robin two-port arbiter that sequences 32-bit requests as two
// 16-bit accesses on a 256K x 16 asynchronous SRAM.
module sram_arbiter_ctrl #(
  parameter int HALF_CYCLES = 2,
  parameter int BUS_AW      = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic [BUS_AW-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_be,
  output logic              p0_done,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic [BUS_AW-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_be,
  output logic              p1_done,
  output logic [31:0]       p1_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [1:0]        sram_be_n,
  output logic [17:0]       sram_addr,
  inout  wire logic [15:0]  sram_dq
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HALF_CYCLES - 1);
  localparam logic [3:0] CNT_PRE  = 4'(HALF_CYCLES - 2);

  state_t            state;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              gnt;
  logic              wr;
  logic [BUS_AW-1:2] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [15:0]       rbuf;
  logic [15:0]       dq_out;
  logic              dq_oe;

  logic              any;
  logic              sel;
  logic              last;
  logic              enter;
  logic              to_resp;
  logic              done_port;
  logic              s_write;
  logic [BUS_AW-1:2] s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_be;
  logic              e_write;
  logic              e_hi;
  logic [BUS_AW-1:2] e_addr;
  logic [31:0]       e_wdata;
  logic [3:0]        e_be;
  logic [1:0]        e_ben;
  logic [15:0]       e_dq;

  logic unused_addr;
  assign unused_addr = ^{p0_addr[1:0], p1_addr[1:0]};

  assign sram_dq = dq_oe ? dq_out : 16'bz;

  always_comb begin
    any     = p0_req | p1_req;
    sel     = (p0_req & p1_req) ? ~last_grant : p1_req;
    s_write = sel ? p1_write : p0_write;
    s_addr  = sel ? p1_addr[BUS_AW-1:2] : p0_addr[BUS_AW-1:2];
    s_wdata = sel ? p1_wdata : p0_wdata;
    s_be    = sel ? p1_be : p0_be;
    last    = (cnt == CNT_LAST);
    if (state == IDLE) begin
      e_write   = s_write;
      e_addr    = s_addr;
      e_wdata   = s_wdata;
      e_be      = s_be;
      e_hi      = s_write && (s_be[1:0] == 2'b00);
      done_port = sel;
    end else begin
      e_write   = wr;
      e_addr    = addr_q;
      e_wdata   = wdata_q;
      e_be      = be_q;
      e_hi      = 1'b1;
      done_port = gnt;
    end
    e_ben = e_write ? ~(e_hi ? e_be[3:2] : e_be[1:0]) : 2'b00;
    e_dq  = e_hi ? e_wdata[31:16] : e_wdata[15:0];
    enter   = 1'b0;
    to_resp = 1'b0;
    case (state)
      IDLE: begin
        enter   = any && !(s_write && (s_be == 4'h0));
        to_resp = any && s_write && (s_be == 4'h0);
      end
      LO: begin
        enter   = last && (!wr || (be_q[3:2] != 2'b00));
        to_resp = last && wr && (be_q[3:2] == 2'b00);
      end
      HI:      to_resp = last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      wr         <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rbuf       <= '0;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 2'b11;
      sram_addr  <= '0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      if (enter) begin
        sram_ce_n <= 1'b0;
        sram_oe_n <= e_write;
        sram_we_n <= ~e_write;
        sram_be_n <= e_ben;
        sram_addr <= {e_addr, e_hi};
        dq_out    <= e_dq;
        dq_oe     <= e_write;
        cnt       <= '0;
      end else if (to_resp) begin
        sram_ce_n <= 1'b1;
        sram_oe_n <= 1'b1;
        sram_we_n <= 1'b1;
        sram_be_n <= 2'b11;
        dq_oe     <= 1'b0;
        p0_done   <= ~done_port;
        p1_done   <= done_port;
      end
      // we_n rises on the final cycle of a write half for hold time
      if ((state == LO || state == HI) && !last) begin
        cnt <= cnt + 4'd1;
        if (wr && cnt == CNT_PRE) sram_we_n <= 1'b1;
      end
      case (state)
        IDLE: if (any) begin
          gnt        <= sel;
          last_grant <= sel;
          wr         <= s_write;
          addr_q     <= s_addr;
          wdata_q    <= s_wdata;
          be_q       <= s_be;
          state      <= to_resp ? RESP : (e_hi ? HI : LO);
        end
        LO: if (last) begin
          if (!wr) rbuf <= sram_dq;
          state <= to_resp ? RESP : HI;
        end
        HI: if (last) begin
          if (!wr && gnt)  p1_rdata <= {sram_dq, rbuf};
          if (!wr && !gnt) p0_rdata <= {sram_dq, rbuf};
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: SRAM model, directed scenarios and
// randomized traffic against a byte-level reference memory.
module tb_sram_arbiter_ctrl;

  localparam int HC = 2;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0;
  logic          p0_write = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [31:0]   p0_wdata = '0;
  logic [3:0]    p0_be = '0;
  logic          p0_done;
  logic [31:0]   p0_rdata;
  logic          p1_req = 1'b0;
  logic          p1_write = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [31:0]   p1_wdata = '0;
  logic [3:0]    p1_be = '0;
  logic          p1_done;
  logic [31:0]   p1_rdata;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [1:0]    sram_be_n;
  logic [17:0]   sram_addr;
  wire  [15:0]   sram_dq;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int last_served = 1;
  logic [31:0] exp_r0 = '0;
  logic [31:0] exp_r1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_ctrl #(.HALF_CYCLES(HC), .BUS_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_done(p0_done),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_done(p1_done),
    .p1_rdata(p1_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .sram_addr(sram_addr), .sram_dq(sram_dq)
  );

  // Asynchronous SRAM model; unwritten words read as zero
  logic [15:0] mem [int];
  logic [15:0] rd_val = '0;
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n)
                 ? rd_val : 16'hzzzz;

  always @(negedge clk) begin
    logic [15:0] w;
    if (!sram_ce_n && !sram_we_n) begin
      w = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 16'h0;
      if (!sram_be_n[0]) w[7:0]  = sram_dq[7:0];
      if (!sram_be_n[1]) w[15:8] = sram_dq[15:8];
      mem[int'(sram_addr)] = w;
    end
    rd_val = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 16'h0;
  end

  // Reference: flat byte memory, bytes of a 32-bit word at addr & ~3
  logic [7:0] ref_mem [0:1023];

  task automatic ref_access(input bit w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] be,
                            output logic [31:0] r);
    int base;
    base = int'(a) & ~3;
    for (int i = 0; i < 4; i++) begin
      if (w && be[i]) ref_mem[base+i] = d[8*i +: 8];
      r[8*i +: 8] = ref_mem[base+i];
    end
  endtask

  function automatic int lat(input bit w, input logic [3:0] be);
    int halves;
    if (!w) halves = 2;
    else halves = ((be[1:0] != 0) ? 1 : 0) + ((be[3:2] != 0) ? 1 : 0);
    return halves * HC + 1;
  endfunction

  task automatic drive(input bit p, input bit w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (!p) begin
      p0_write = w; p0_addr = a; p0_wdata = d; p0_be = be; p0_req = 1'b1;
    end else begin
      p1_write = w; p1_addr = a; p1_wdata = d; p1_be = be; p1_req = 1'b1;
    end
  endtask

  task automatic wait_done(input bit w0, input bit w1, input int budget,
                           output int d0, output int d1,
                           output logic [31:0] r0, output logic [31:0] r1);
    d0 = -1; d1 = -1; r0 = '0; r1 = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (p0_done) begin d0 = cyc - t0; r0 = p0_rdata; end
      if (p1_done) begin d1 = cyc - t0; r1 = p1_rdata; end
      @(posedge clk); #1;
      if (d0 >= 0) p0_req = 1'b0;
      if (d1 >= 0) p1_req = 1'b0;
      if ((!w0 || d0 >= 0) && (!w1 || d1 >= 0)) break;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ctrl: ce/oe/we_n=%b want 111",
               {sram_ce_n, sram_oe_n, sram_we_n});
    end
    tests++;
    if (sram_be_n !== 2'b11 || sram_addr !== 18'h0) begin
      fails++;
      $display("FAIL reset_addr: be_n=%b addr=%h want 11/0",
               sram_be_n, sram_addr);
    end
    tests++;
    if ({p0_done, p1_done} !== 2'b00 || p0_rdata !== 0 || p1_rdata !== 0)
    begin
      fails++;
      $display("FAIL reset_port: done=%b r0=%h r1=%h want 0",
               {p0_done, p1_done}, p0_rdata, p1_rdata);
    end
    rst_n = 1'b1;
    exp_r0 = '0; exp_r1 = '0; last_served = 1;
  endtask

  task automatic test_tie();
    int d0, d1;
    logic [31:0] r0, r1, e0, e1, wd;
    ref_access(1'b1, 19'h40, 32'h12345678, 4'hF, e0);
    ref_access(1'b0, 19'h40, 32'h0, 4'h0, e1);
    @(posedge clk); #1;
    drive(0, 1'b1, 19'h40, 32'h12345678, 4'hF);
    drive(1, 1'b0, 19'h40, 32'h0, 4'hF);
    t0 = cyc;
    wait_done(1'b1, 1'b1, 40, d0, d1, r0, r1);
    tests++;
    if (d0 !== 5 || d1 !== 11) begin
      fails++;
      $display("FAIL tie1_latency: p0=%0d p1=%0d want 5/11", d0, d1);
    end
    tests++;
    if (r1 !== e1) begin
      fails++;
      $display("FAIL tie1_rdata: p1=%h want %h", r1, e1);
    end
    exp_r1 = e1;
    wd = $urandom;
    ref_access(1'b0, 19'h40, 32'h0, 4'h0, e0);
    ref_access(1'b1, 19'h44, wd, 4'h3, e1);
    @(posedge clk); #1;
    drive(0, 1'b0, 19'h40, 32'h0, 4'h0);
    drive(1, 1'b1, 19'h44, wd, 4'h3);
    t0 = cyc;
    wait_done(1'b1, 1'b1, 40, d0, d1, r0, r1);
    tests++;
    if (d0 !== 5 || d1 !== 5 + 1 + lat(1'b1, 4'h3)) begin
      fails++;
      $display("FAIL tie2_latency: p0=%0d p1=%0d want 5/%0d",
               d0, d1, 5 + 1 + lat(1'b1, 4'h3));
    end
    tests++;
    if (r0 !== e0) begin
      fails++;
      $display("FAIL tie2_rdata: p0=%h want %h", r0, e0);
    end
    exp_r0 = e0;
    last_served = 1;
  endtask

  task automatic test_full_write();
    logic [31:0] e;
    logic [17:0] ea;
    logic [15:0] ed;
    logic ew;
    ref_access(1'b1, 19'h10, 32'hDEADBEEF, 4'hF, e);
    @(posedge clk); #1;
    drive(1, 1'b1, 19'h10, 32'hDEADBEEF, 4'hF);
    t0 = cyc;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        ea = (k <= 2) ? 18'h8 : 18'h9;
        ed = (k <= 2) ? 16'hBEEF : 16'hDEAD;
        ew = (k == 1 || k == 3) ? 1'b0 : 1'b1;
        tests++;
        if (sram_addr !== ea || sram_dq !== ed || sram_we_n !== ew ||
            sram_ce_n !== 1'b0 || sram_oe_n !== 1'b1 ||
            sram_be_n !== 2'b00) begin
          fails++;
          $display("FAIL full_write c%0d: a=%h dq=%h we=%b ce=%b oe=%b be=%b want a=%h dq=%h we=%b ce=0 oe=1 be=00",
                   k, sram_addr, sram_dq, sram_we_n, sram_ce_n,
                   sram_oe_n, sram_be_n, ea, ed, ew);
        end
      end
      tests++;
      if (p1_done !== (k == 5) || p0_done !== 1'b0) begin
        fails++;
        $display("FAIL full_write_done c%0d: p1=%b p0=%b want %b/0",
                 k, p1_done, p0_done, k == 5);
      end
    end
    @(posedge clk); #1;
    p1_req = 1'b0;
    last_served = 1;
  endtask

  task automatic test_readback();
    logic [31:0] e;
    logic [17:0] ea;
    ref_access(1'b0, 19'h10, 32'h0, 4'h0, e);
    @(posedge clk); #1;
    drive(0, 1'b0, 19'h10, 32'h0, 4'h0);
    t0 = cyc;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        ea = (k <= 2) ? 18'h8 : 18'h9;
        tests++;
        if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 ||
            sram_ce_n !== 1'b0 || sram_be_n !== 2'b00 ||
            sram_addr !== ea) begin
          fails++;
          $display("FAIL readback c%0d: oe=%b we=%b ce=%b be=%b a=%h want 0/1/0/00/%h",
                   k, sram_oe_n, sram_we_n, sram_ce_n, sram_be_n,
                   sram_addr, ea);
        end
      end
    end
    tests++;
    if (p0_done !== 1'b1 || p0_rdata !== e) begin
      fails++;
      $display("FAIL readback_data: done=%b rdata=%h want 1/%h",
               p0_done, p0_rdata, e);
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    exp_r0 = e;
    last_served = 0;
  endtask

  task automatic test_byte_write();
    logic [31:0] e;
    ref_access(1'b1, 19'h20, 32'h00AA0000, 4'h4, e);
    @(posedge clk); #1;
    drive(1, 1'b1, 19'h20, 32'h00AA0000, 4'h4);
    t0 = cyc;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 2) begin
        tests++;
        if (sram_addr !== 18'h11 || sram_be_n !== 2'b10 ||
            sram_dq !== 16'h00AA || sram_ce_n !== 1'b0 ||
            sram_we_n !== (k == 2)) begin
          fails++;
          $display("FAIL byte_write c%0d: a=%h be=%b dq=%h ce=%b we=%b want 11/10/00aa/0/%b",
                   k, sram_addr, sram_be_n, sram_dq, sram_ce_n,
                   sram_we_n, k == 2);
        end
      end
      tests++;
      if (p1_done !== (k == 3)) begin
        fails++;
        $display("FAIL byte_write_done c%0d: %b want %b",
                 k, p1_done, k == 3);
      end
    end
    @(posedge clk); #1;
    p1_req = 1'b0;
    last_served = 1;
  endtask

  task automatic test_empty_write();
    @(posedge clk); #1;
    drive(0, 1'b1, 19'h30, $urandom, 4'h0);
    t0 = cyc;
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      tests++;
      if (sram_ce_n !== 1'b1 || sram_we_n !== 1'b1 ||
          p0_done !== (k == 1)) begin
        fails++;
        $display("FAIL empty_write c%0d: ce=%b we=%b done=%b want 1/1/%b",
                 k, sram_ce_n, sram_we_n, p0_done, k == 1);
      end
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    last_served = 0;
  endtask

  task automatic test_reset_mid_write();
    int d0, d1, seen;
    logic [31:0] r0, r1, e0, e1;
    @(posedge clk); #1;
    drive(1, 1'b1, 19'h400, 32'h12345678, 4'hF);
    t0 = cyc;
    for (int k = 0; k <= 3; k++) @(negedge clk);
    tests++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'h201 ||
        sram_dq !== 16'h1234) begin
      fails++;
      $display("FAIL mid_write_pre: we=%b a=%h dq=%h want 0/201/1234",
               sram_we_n, sram_addr, sram_dq);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111 ||
        sram_dq === 16'h1234) begin
      fails++;
      $display("FAIL mid_write_async: ce/oe/we=%b dq=%h want 111, dq released",
               {sram_ce_n, sram_oe_n, sram_we_n}, sram_dq);
    end
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (p0_done || p1_done) seen++;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (p0_done || p1_done) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL mid_write_nodone: %0d pulses want 0", seen);
    end
    exp_r0 = '0; exp_r1 = '0;
    ref_access(1'b0, 19'h44, 32'h0, 4'h0, e0);
    ref_access(1'b0, 19'h20, 32'h0, 4'h0, e1);
    @(posedge clk); #1;
    drive(0, 1'b0, 19'h44, 32'h0, 4'hF);
    drive(1, 1'b0, 19'h20, 32'h0, 4'hF);
    t0 = cyc;
    wait_done(1'b1, 1'b1, 40, d0, d1, r0, r1);
    tests++;
    if (d0 !== 5 || d1 !== 11 || r0 !== e0 || r1 !== e1) begin
      fails++;
      $display("FAIL post_reset_tie: d=%0d/%0d r=%h/%h want 5/11 %h/%h",
               d0, d1, r0, r1, e0, e1);
    end
    exp_r0 = e0; exp_r1 = e1;
    last_served = 1;
  endtask

  task automatic test_random(input int n);
    bit          act [2];
    bit          w   [2];
    logic [18:0] a   [2];
    logic [31:0] d   [2];
    logic [3:0]  be  [2];
    logic [31:0] er  [2];
    int          ed  [2];
    int          mode, f, s, dn0, dn1;
    logic [31:0] r0, r1;
    for (int it = 0; it < n; it++) begin
      mode = $urandom_range(0, 2);
      act[0] = (mode != 1);
      act[1] = (mode != 0);
      for (int p = 0; p < 2; p++) begin
        w[p]  = 1'($urandom_range(0, 1));
        a[p]  = 19'($urandom_range(0, 255));
        d[p]  = $urandom;
        be[p] = 4'($urandom_range(0, 15));
      end
      f = (mode == 2) ? 1 - last_served : ((mode == 0) ? 0 : 1);
      s = 1 - f;
      ref_access(w[f], a[f], d[f], be[f], er[f]);
      ed[f] = lat(w[f], be[f]);
      if (mode == 2) begin
        ref_access(w[s], a[s], d[s], be[s], er[s]);
        ed[s] = ed[f] + 1 + lat(w[s], be[s]);
      end
      last_served = (mode == 2) ? s : f;
      @(posedge clk); #1;
      if (act[0]) drive(0, w[0], a[0], d[0], be[0]);
      if (act[1]) drive(1, w[1], a[1], d[1], be[1]);
      t0 = cyc;
      wait_done(act[0], act[1], 40, dn0, dn1, r0, r1);
      if (act[0]) begin
        tests++;
        if (dn0 !== ed[0] || (!w[0] && r0 !== er[0])) begin
          fails++;
          $display("FAIL rand%0d_p0: done@%0d r=%h want @%0d r=%h (w=%b)",
                   it, dn0, r0, ed[0], er[0], w[0]);
        end
        if (!w[0]) exp_r0 = er[0];
      end
      if (act[1]) begin
        tests++;
        if (dn1 !== ed[1] || (!w[1] && r1 !== er[1])) begin
          fails++;
          $display("FAIL rand%0d_p1: done@%0d r=%h want @%0d r=%h (w=%b)",
                   it, dn1, r1, ed[1], er[1], w[1]);
        end
        if (!w[1]) exp_r1 = er[1];
      end
      tests++;
      if (p0_rdata !== exp_r0 || p1_rdata !== exp_r1) begin
        fails++;
        $display("FAIL rand%0d_hold: r0=%h r1=%h want %h/%h",
                 it, p0_rdata, p1_rdata, exp_r0, exp_r1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_tie();
    test_full_write();
    test_readback();
    test_byte_write();
    test_empty_write();
    test_reset_mid_write();
    test_random(60);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
